// File: rtl/cpu_clk_sched.sv
// rtl/cpu_clk_sched.sv - CPU clock-enable scheduler with run/stop/step sequencing and bus hold
// Optional pulse counter: define CPU_CLK_SCHED_CYCLE_COUNT_EN.
module cpu_clk_sched #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 step_req,
    output logic                 step_ack,
    input  logic                 hold_req,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    output logic                 cpu_ce,
    output logic                 running,
    output logic [31:0]          cycle_count
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2
    } state_t;

    state_t               state_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 cpu_ce_q;
    logic                 step_ack_q;
    logic                 running_q;

    logic active;
    logic term;
    logic tick;
    logic stop_now;

    always_comb begin
        active   = (state_q != ST_STOPPED);
        term     = (cnt_q == (div_q - DIV_WIDTH'(1)));
        // A divisor load restarts the phase, so it wins over a tick due this cycle.
        tick     = active && term && !hold_req && !div_load;
        stop_now = (state_q == ST_RUNNING) && !run;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_STOPPED;
            div_q      <= DIV_WIDTH'(DEFAULT_DIV);
            cnt_q      <= '0;
            cpu_ce_q   <= 1'b0;
            step_ack_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            cpu_ce_q   <= tick;
            step_ack_q <= tick && (state_q == ST_STEPPING);

            case (state_q)
                ST_STOPPED: begin
                    if (run) begin
                        state_q   <= ST_RUNNING;
                        running_q <= 1'b1;
                    end else if (step_req) begin
                        state_q <= ST_STEPPING;
                    end
                end
                ST_RUNNING: begin
                    if (!run) begin
                        state_q   <= ST_STOPPED;
                        running_q <= 1'b0;
                    end
                end
                ST_STEPPING: begin
                    if (tick) begin
                        state_q <= ST_STOPPED;
                    end
                end
                default: begin
                    state_q   <= ST_STOPPED;
                    running_q <= 1'b0;
                end
            endcase

            // A held terminal count parks at N-1 so the tick fires as soon as hold drops.
            if (div_load) begin
                div_q <= (div_value == '0) ? DIV_WIDTH'(1) : div_value;
                cnt_q <= '0;
            end else if (!active || stop_now || tick) begin
                cnt_q <= '0;
            end else if (!term) begin
                cnt_q <= cnt_q + DIV_WIDTH'(1);
            end
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign step_ack = step_ack_q;
    assign running  = running_q;

`ifdef CPU_CLK_SCHED_CYCLE_COUNT_EN
    logic [31:0] cycle_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= 32'd0;
        end else if (cpu_ce_q) begin
            cycle_count_q <= cycle_count_q + 32'd1;
        end
    end

    assign cycle_count = cycle_count_q;
`else
    assign cycle_count = 32'd0;
`endif

endmodule

// File: doc/cpu_clk_sched.md
# cpu_clk_sched

Clock-enable scheduler for the 6502 core. It derives a one-cycle `cpu_ce` pulse from the single system clock using a runtime-programmable divisor. It also sequences run, stop and single-step requests from the debug/UART monitor, and stalls CPU cycles while a peripheral holds the bus. It replaces free-running divided clocks: every CPU-side register runs on `clk` and is gated by `cpu_ce`.

## Interface
- `DIV_WIDTH`, 8: width of the divisor and the phase counter.
- `DEFAULT_DIV`, 25: divisor loaded at reset (25 MHz gives a 1 MHz CPU).

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = free-run requested, 0 = stop requested.
- `step_req`  in  1  one-cycle pulse; request exactly one CPU cycle while stopped.
- `step_ack`  out  1  one-cycle pulse; the step's `cpu_ce` was issued.
- `hold_req`  in  1  level; peripheral bus hold, defers any due `cpu_ce`.
- `div_load`  in  1  one-cycle strobe; load `div_value`.
- `div_value`  in  DIV_WIDTH  new divisor N.
- `cpu_ce`  out  1  registered CPU clock enable; at most one cycle high per tick.
- `running`  out  1  registered; 1 in RUNNING.
- `cycle_count`  out  32  number of `cpu_ce` pulses issued (see Configuration).

## Operation
- Registers:
  - `state` ∈ {STOPPED, RUNNING, STEPPING}.
  - `div` holds the effective divisor N; `div_value` = 0 is stored as 1.
  - `cnt` counts 0..N-1.
- Terminal condition T = (`cnt` == N-1).
  - In RUNNING or STEPPING: if T and `hold_req` = 0, then `cnt` ← 0 and `cpu_ce` ← 1 next cycle.
  - In RUNNING or STEPPING: if T and `hold_req` = 1, `cnt` holds at N-1 and `cpu_ce` ← 0. The deferred tick fires on the first cycle `hold_req` = 0.
  - In RUNNING or STEPPING, otherwise: `cnt` increments and `cpu_ce` ← 0.
  - In STOPPED: `cnt` ← 0 and `cpu_ce` ← 0.
- Transitions:
  - STOPPED → RUNNING when `run` = 1. `step_req` is ignored in this cycle; run has priority.
  - STOPPED → STEPPING when `run` = 0 and `step_req` = 1.
  - RUNNING → STOPPED when `run` = 0. `cnt` ← 0 and any partially counted tick is discarded. If T and `hold_req` = 0 in that same cycle, the tick still issues; the stop takes effect after it.
  - STEPPING → STOPPED on the tick. `cpu_ce` and `step_ack` are asserted together in the following cycle. `run` and `step_req` are ignored while in STEPPING. If `run` = 1 at completion, RUNNING is entered one cycle later via STOPPED.
- `div_load`, in any state:
  - `div` ← max(`div_value`, 1) and `cnt` ← 0; the load overrides the tick in the same cycle.
  - In STEPPING, the step continues with the new divisor.
- Reset: state STOPPED, `cnt` = 0, `div` = DEFAULT_DIV.
  - All outputs are 0: `cpu_ce`, `step_ack`, `running`, `cycle_count`.
  - Reset mid-step aborts the step; no `step_ack` is issued.

## Timing
- In RUNNING with no hold, `cpu_ce` is high 1 cycle in every N, at fixed phase.
- First `cpu_ce` comes N cycles after the edge on which `state` becomes RUNNING.
- N = 1: `cpu_ce` is high every cycle.
- Step latency: `step_ack`/`cpu_ce` appear N+1 cycles after the `step_req` cycle (1 cycle to enter STEPPING, then N).
- `hold_req` has one cycle of latency. If `hold_req` is high in cycle t, `cpu_ce` is guaranteed low at t+1. After `hold_req` falls at t, a pending tick is issued at t+1.
- `running` updates one cycle after the transition condition is sampled.
- `cnt` never exceeds N-1. Loading a smaller N mid-count is safe because `cnt` is cleared.

## Configuration
- `CPU_CLK_SCHED_CYCLE_COUNT_EN` defined:
  - `cycle_count` is a 32-bit register, cleared by `rst`.
  - It increments on every cycle `cpu_ce` = 1 and wraps from 0xFFFFFFFF to 0.
- Undefined: `cycle_count` is tied to 0 and no counter logic is generated. The port is always present.

## Test plan
- Reset, `run` = 1, N = 25 → first `cpu_ce` 25 cycles after entering RUNNING, then every 25 cycles. `running` = 1.
- `run` = 0, `step_req` pulse with N = 4 → exactly one `cpu_ce` with `step_ack`, 5 cycles after the pulse. A second `step_req` during STEPPING is ignored.
- RUNNING with N = 3, `hold_req` high for 10 cycles across a tick → no `cpu_ce` during the hold. One `cpu_ce` the cycle after release, then every 3 cycles.
- `div_load` of `div_value` = 0 while running → `cpu_ce` every cycle. `div_load` of 7 → `cnt` cleared, next `cpu_ce` 7 cycles later.
- `run` drops mid-count, then `rst` asserted during STEPPING → no further `cpu_ce`, no `step_ack`, all outputs 0, `div` = 25.
- With `CPU_CLK_SCHED_CYCLE_COUNT_EN` defined, N = 1, 100 cycles running → `cycle_count` = 100. Without the macro → `cycle_count` stays 0.
